ram_bus_master: RTL

//   CPU-side initiator for the shared 4K x 32 RAM bus (Addr / bidirectional Data / R_W / CS).

---
 rtl/ram_bus_master_if.sv | 31 +++
 rtl/ram_bus_master.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ram_bus_master_if.sv
// Request, write-data and response handshake bundle between the control path and ram_bus_master.
// The RAM-side bus (address, tristate data, R_W, CS) stays on plain module ports.
interface ram_bus_master_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 3
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;

   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;

   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_last;

   modport master (
      input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
      output req_ready, wr_ready, rsp_valid, rsp_data, rsp_last
   );

   modport slave (
      output req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
      input  req_ready, wr_ready, rsp_valid, rsp_data, rsp_last
   );
endinterface

// File: rtl/ram_bus_master.sv
// CPU-side initiator for the shared RAM bus: sequences single/burst reads and writes beat by beat
// and owns the tristate data bus whenever mem_r_w is high.
module ram_bus_master #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 3,
   parameter int RD_WAIT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   ram_bus_master_if.master  bus,
   output logic [ADDR_W-1:0] mem_addr,
   inout  wire  [DATA_W-1:0] mem_data,
   output logic              mem_r_w,
   output logic              mem_cs
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ACC,
      RD_CAP,
      WR_WAIT,
      WR_COMMIT,
      TURN
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT);

   state_t            state;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt;
   logic [3:0]        wait_cnt;
   logic [DATA_W-1:0] wdata_q;

   assign bus.req_ready = rst_n && (state == IDLE);
   assign bus.wr_ready  = (state == WR_WAIT);

   // Drive enable is the mem_r_w register itself, so the RAM and this block can never drive together.
   assign mem_data = mem_r_w ? wdata_q : {DATA_W{1'bz}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         mem_cs        <= 1'b0;
         mem_r_w       <= 1'b1;
         mem_addr      <= '0;
         wdata_q       <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_last  <= 1'b0;
         len_q         <= '0;
         cnt           <= '0;
         wait_cnt      <= '0;
      end else begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_last  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  len_q    <= bus.req_len;
                  cnt      <= '0;
                  mem_addr <= bus.req_addr;
                  wait_cnt <= '0;
                  if (bus.req_we) begin
                     state <= WR_WAIT;
                  end else begin
                     state   <= RD_ACC;
                     mem_cs  <= 1'b1;
                     mem_r_w <= 1'b0;
                  end
               end
            end

            // The first beat spends one extra cycle here to turn the data bus around;
            // later beats enter with wait_cnt=1 so the beat period is RD_WAIT+1.
            RD_ACC: begin
               if (wait_cnt == WAIT_LAST) begin
                  state <= RD_CAP;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end

            RD_CAP: begin
               bus.rsp_valid <= 1'b1;
               bus.rsp_data  <= mem_data;
               bus.rsp_last  <= (cnt == len_q);
               if (cnt == len_q) begin
                  state   <= TURN;
                  mem_cs  <= 1'b0;
                  mem_r_w <= 1'b1;
               end else begin
                  mem_addr <= mem_addr + ADDR_W'(1);
                  cnt      <= cnt + LEN_W'(1);
                  wait_cnt <= 4'd1;
                  state    <= (RD_WAIT == 0) ? RD_CAP : RD_ACC;
               end
            end

            WR_WAIT: begin
               if (bus.wr_valid) begin
                  wdata_q <= bus.wr_data;
                  mem_cs  <= 1'b1;
                  state   <= WR_COMMIT;
               end
            end

            WR_COMMIT: begin
               mem_cs <= 1'b0;
               if (cnt == len_q) begin
                  state         <= TURN;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_last  <= 1'b1;
                  bus.rsp_data  <= '0;
               end else begin
                  mem_addr <= mem_addr + ADDR_W'(1);
                  cnt      <= cnt + LEN_W'(1);
                  state    <= WR_WAIT;
               end
            end

            TURN: begin
               state <= IDLE;
            end

            default: begin
               state   <= IDLE;
               mem_cs  <= 1'b0;
               mem_r_w <= 1'b1;
            end
         endcase
      end
   end

endmodule
